// File: rtl/dbg_disp_ctrl_if.sv
// Debug display controller bus interface.
// Groups the capture, control and display signals of dbg_disp_ctrl.
//   master : drives writes, hold, key and auto-scroll; observes the display outputs
//   slave  : the controller itself
interface dbg_disp_ctrl_if;
  logic        i_wr;        // write strobe, one cycle per word
  logic [1:0]  i_wr_addr;   // target page 0..3
  logic [31:0] i_wr_data;   // debug word
  logic        i_hold;      // 1 freezes all pages
  logic        i_key_next;  // raw push-button, asynchronous
  logic        i_auto;      // 1 enables auto-scroll
  logic [31:0] o_hex;       // displayed word, nibble k -> digit k
  logic [7:0]  o_blank;     // bit k = 1 blanks digit k
  logic [1:0]  o_page;      // currently displayed page
  logic        o_tick;      // registered display tick pulse

  modport master (
    output i_wr, i_wr_addr, i_wr_data, i_hold, i_key_next, i_auto,
    input  o_hex, o_blank, o_page, o_tick
  );

  modport slave (
    input  i_wr, i_wr_addr, i_wr_data, i_hold, i_key_next, i_auto,
    output o_hex, o_blank, o_page, o_tick
  );
endinterface

// File: rtl/dbg_disp_ctrl.sv
// Debug display controller.
// Captures up to four 32-bit debug words into page registers, selects one page for
// display (push-button or timed auto-scroll) and presents eight registered nibbles
// plus a leading-zero blank mask to the per-digit segment decoders.
//
// Ports:
//   i_clk  system clock
//   i_rst  asynchronous reset, active-high
//   bus    dbg_disp_ctrl_if.slave (write port, hold, key, auto, display outputs)
//
// Parameters:
//   TICK_DIV    system clocks per display tick
//   AUTO_TICKS  ticks per page in auto-scroll mode (1..255)
//
// Optional feature: define DBG_DISP_BLINK_EN to blink the whole display (o_blank
// forced to 8'hFF on alternate ticks) while i_hold is asserted.
module dbg_disp_ctrl #(
  parameter int unsigned TICK_DIV   = 2500000,
  parameter int unsigned AUTO_TICKS = 20
) (
  input  logic            i_clk,
  input  logic            i_rst,
  dbg_disp_ctrl_if.slave  bus
);

  localparam int unsigned     CntW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] TickLast = CntW'(TICK_DIV - 1);
  localparam logic [7:0]      AutoLast = 8'(AUTO_TICKS - 1);

  logic [CntW-1:0] tick_cnt_q;
  logic            tick_q;
  logic [7:0]      auto_cnt_q, auto_cnt_d;
  logic [2:0]      key_sync_q;  // [0] first flop, [1] second flop, [2] edge-detect history
  logic [31:0]     page_q [4];
  logic [1:0]      cur_page_q, page_d;
  logic [31:0]     hex_q, hex_d;
  logic [7:0]      blank_q, blank_d;
  logic            key_edge, auto_wrap;

  // Bit k (k >= 1) set iff nibbles 7..k are all zero; bit 0 never set.
  function automatic logic [7:0] lz_mask(input logic [31:0] v);
    logic [7:0] m;
    logic       run;
    m   = 8'h00;
    run = 1'b1;
    for (int k = 7; k >= 1; k--) begin
      run  = run & (v[4*k +: 4] == 4'h0);
      m[k] = run;
    end
    return m;
  endfunction

  always_comb begin
    key_edge  = key_sync_q[1] & ~key_sync_q[2];
    auto_wrap = bus.i_auto & tick_q & (auto_cnt_q == AutoLast);
    // Coincident key edge and auto advance still move by a single page.
    page_d    = cur_page_q + {1'b0, key_edge | auto_wrap};

    auto_cnt_d = auto_cnt_q;
    if (!bus.i_auto || key_edge) begin
      auto_cnt_d = 8'd0;
    end else if (tick_q) begin
      auto_cnt_d = auto_wrap ? 8'd0 : auto_cnt_q + 8'd1;
    end

    // Pages are read before this edge's write lands, so a write shows one cycle later.
    hex_d = page_q[page_d];
  end

`ifdef DBG_DISP_BLINK_EN
  logic blink_q, blink_d;

  always_comb begin
    blink_d = bus.i_hold ? (blink_q ^ tick_q) : 1'b0;
    blank_d = blink_d ? 8'hFF : lz_mask(hex_d);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      blink_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
    end
  end
`else
  always_comb begin
    blank_d = lz_mask(hex_d);
  end
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
      auto_cnt_q <= 8'd0;
      key_sync_q <= 3'b000;
      cur_page_q <= 2'd0;
      hex_q      <= 32'h0;
      blank_q    <= 8'hFE;
      for (int i = 0; i < 4; i++) begin
        page_q[i] <= 32'h0;
      end
    end else begin
      tick_cnt_q <= (tick_cnt_q == TickLast) ? '0 : tick_cnt_q + 1'b1;
      tick_q     <= (tick_cnt_q == TickLast);
      key_sync_q <= {key_sync_q[1], key_sync_q[0], bus.i_key_next};
      auto_cnt_q <= auto_cnt_d;
      cur_page_q <= page_d;
      hex_q      <= hex_d;
      blank_q    <= blank_d;
      if (bus.i_wr && !bus.i_hold) begin
        page_q[bus.i_wr_addr] <= bus.i_wr_data;
      end
    end
  end

  assign bus.o_hex   = hex_q;
  assign bus.o_blank = blank_q;
  assign bus.o_page  = cur_page_q;
  assign bus.o_tick  = tick_q;

endmodule

// File: tb/tb_dbg_disp_ctrl.sv
// Self-checking bench for dbg_disp_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural model of the display controller.
module tb_dbg_disp_ctrl;

  localparam int unsigned TickDiv   = 4;
  localparam int unsigned AutoTicks = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  dbg_disp_ctrl_if bus ();

  dbg_disp_ctrl #(
    .TICK_DIV   (TickDiv),
    .AUTO_TICKS (AutoTicks)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_pages [4];
  int          m_page;
  logic [31:0] m_hex;
  logic        m_tick;
  logic        m_blink;
  int          m_edges;       // clock edges since reset release
  int          m_ticks_seen;  // ticks counted toward the next auto advance
  logic        m_key_hist [$];  // key level sampled at each edge, newest last

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_mask(input logic [31:0] v);
    int lz = 0;
    for (int k = 7; k >= 1; k--) begin
      if (v[4*k +: 4] != 4'h0) break;
      lz++;
    end
    return 8'(8'hFF << (8 - lz));
  endfunction

  function automatic logic [7:0] exp_blank();
    return m_blink ? 8'hFF : exp_mask(m_hex);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_pages[i] = 32'h0;
    m_page       = 0;
    m_hex        = 32'h0;
    m_tick       = 1'b0;
    m_blink      = 1'b0;
    m_edges      = 0;
    m_ticks_seen = 0;
    m_key_hist.delete();
  endtask

  // Key level at edge n (edges before reset release read as 0).
  function automatic logic key_at(input int n);
    if (n < 1 || n > m_key_hist.size()) return 1'b0;
    return m_key_hist[n-1];
  endfunction

  // Advance the model by one clock edge using the inputs presented to that edge.
  task automatic model_step();
    logic key_edge, advance;
    m_edges++;
    key_edge = key_at(m_edges - 2) && !key_at(m_edges - 3);
    m_key_hist.push_back(bus.i_key_next);
    advance = 1'b0;
    if (!bus.i_auto) begin
      m_ticks_seen = 0;
    end else if (m_tick) begin
      m_ticks_seen++;
      if (m_ticks_seen == AutoTicks) begin
        m_ticks_seen = 0;
        advance      = 1'b1;
      end
    end
    if (key_edge) m_ticks_seen = 0;
    if (key_edge || advance) m_page = (m_page + 1) % 4;
`ifdef DBG_DISP_BLINK_EN
    if (!bus.i_hold) m_blink = 1'b0;
    else if (m_tick) m_blink = ~m_blink;
`endif
    m_hex = m_pages[m_page];
    if (bus.i_wr && !bus.i_hold) m_pages[bus.i_wr_addr] = bus.i_wr_data;
    m_tick = ((m_edges % TickDiv) == 0);
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, ".hex"},   bus.o_hex,           m_hex);
    check_val({tag, ".blank"}, 32'(bus.o_blank),    32'(exp_blank()));
    check_val({tag, ".page"},  32'(bus.o_page),     32'(m_page));
    check_val({tag, ".tick"},  32'(bus.o_tick),     32'(m_tick));
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle_inputs();
    bus.i_wr       = 1'b0;
    bus.i_wr_addr  = 2'd0;
    bus.i_wr_data  = 32'h0;
    bus.i_hold     = 1'b0;
    bus.i_key_next = 1'b0;
    bus.i_auto     = 1'b0;
  endtask

  task automatic write_word(input logic [1:0] addr, input logic [31:0] data, input string tag);
    bus.i_wr      = 1'b1;
    bus.i_wr_addr = addr;
    bus.i_wr_data = data;
    cycle(tag);
    bus.i_wr      = 1'b0;
  endtask

  task automatic key_pulse(input string tag);
    bus.i_key_next = 1'b1;
    repeat (2) cycle(tag);
    bus.i_key_next = 1'b0;
    repeat (4) cycle(tag);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check_val("rst.hex",   bus.o_hex,           32'h0);
    check_val("rst.blank", 32'(bus.o_blank),    32'hFE);
    check_val("rst.page",  32'(bus.o_page),     32'd0);
    check_val("rst.tick",  32'(bus.o_tick),     32'd0);
    rst = 1'b0;

    // 1: capture and leading-zero mask
    write_word(2'd0, 32'h0000_C0DE, "t1.wr");
    cycle("t1");
    check_val("t1.hex_c0de", bus.o_hex,        32'h0000_C0DE);
    check_val("t1.blank_f0", 32'(bus.o_blank), 32'hF0);

    // 2: hold drops writes, release accepts them
    bus.i_hold = 1'b1;
    write_word(2'd0, 32'h1234_5678, "t2.hold");
    repeat (2) cycle("t2.hold");
    check_val("t2.held_hex", bus.o_hex, 32'h0000_C0DE);
    bus.i_hold = 1'b0;
    write_word(2'd0, 32'h1234_5678, "t2.wr");
    cycle("t2");
    check_val("t2.hex",      bus.o_hex,        32'h1234_5678);
    check_val("t2.blank_00", 32'(bus.o_blank), 32'h00);

    // 3: back-to-back writes, manual paging
    write_word(2'd1, 32'h0000_0001, "t3.wr");
    write_word(2'd2, 32'h0000_0000, "t3.wr");
    write_word(2'd3, 32'hFFFF_FFFF, "t3.wr");
    for (int p = 0; p < 4; p++) key_pulse("t3.key");
    check_val("t3.page_wrap", 32'(bus.o_page), 32'd0);

    // 4: auto-scroll, with key pulses sweeping all phases of the advance period
    bus.i_auto = 1'b1;
    repeat (30) cycle("t4.auto");
    for (int i = 0; i < 13; i++) begin
      bus.i_key_next = 1'b1;
      cycle("t4.key");
      bus.i_key_next = 1'b0;
      repeat (12) cycle("t4.key");
    end

    // 5: reset mid-scroll with a key edge in flight
    for (int i = 0; i < 40 && m_page != 2; i++) cycle("t5.seek");
    check_val("t5.page2", 32'(bus.o_page), 32'd2);
    bus.i_key_next = 1'b1;
    cycle("t5.key");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("t5.rst");
    @(posedge clk);
    #2;
    bus.i_key_next = 1'b0;
    bus.i_auto     = 1'b0;
    rst            = 1'b0;
    repeat (8) cycle("t5.after");
    check_val("t5.no_change", 32'(bus.o_page), 32'd0);

`ifdef DBG_DISP_BLINK_EN
    // 6: blink while held
    write_word(2'd0, 32'h0000_00A5, "t6.wr");
    bus.i_hold = 1'b1;
    repeat (20) cycle("t6.blink");
    bus.i_hold = 1'b0;
    cycle("t6.release");
    check_val("t6.mask_back", 32'(bus.o_blank), 32'hFC);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.i_wr      = ($urandom_range(0, 2) == 0);
      bus.i_wr_addr = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       bus.i_wr_data = 32'h0;
        1:       bus.i_wr_data = $urandom() >> $urandom_range(0, 31);
        default: bus.i_wr_data = $urandom();
      endcase
      if ($urandom_range(0, 15) == 0) bus.i_hold = ~bus.i_hold;
      if ($urandom_range(0, 3) == 0) bus.i_key_next = ~bus.i_key_next;
      if ($urandom_range(0, 31) == 0) bus.i_auto = ~bus.i_auto;
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
